// File: rtl/apb_master_pkg.sv
// Shared definitions for the APB master bridge: FSM state encoding and
// default bus geometry / timeout values used by the interface and the RTL.
package apb_master_pkg;

    localparam int unsigned APB_ADDR_W  = 3;
    localparam int unsigned APB_DATA_W  = 8;
    localparam int unsigned APB_TIMEOUT = 15;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_t;

endpackage

// File: rtl/apb_master_bridge_if.sv
// Bundle of the host command/response handshake and the APB bus seen by the
// bridge.
//   master modport : bridge side (takes commands, drives APB, returns rsp)
//   slave modport  : environment side (host + APB slave)
// Signals:
//   cmd_valid/cmd_ready/cmd_write/cmd_addr/cmd_wdata  host command
//   rsp_valid/rsp_rdata/rsp_err/rsp_timeout           registered response
//   psel/penable/pwrite/paddr/pwdata/prdata/pslverr/pready  APB bus
interface apb_master_bridge_if
    import apb_master_pkg::*;
#(
    parameter int unsigned ADDR_W = APB_ADDR_W,
    parameter int unsigned DATA_W = APB_DATA_W
) ();

    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;

    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic              rsp_timeout;

    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [ADDR_W-1:0] paddr;
    logic [DATA_W-1:0] pwdata;
    logic [DATA_W-1:0] prdata;
    logic              pslverr;
    logic              pready;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        output cmd_ready,
        output rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
        output psel, penable, pwrite, paddr, pwdata,
        input  prdata, pslverr, pready
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        input  cmd_ready,
        input  rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
        input  psel, penable, pwrite, paddr, pwdata,
        output prdata, pslverr, pready
    );

endinterface

// File: rtl/apb_timeout_counter.sv
// Saturating wait-state counter for the ACCESS phase.
// Ports:
//   clk, rst  clock / async active-high reset
//   clear     zero the count (transfer start)
//   enable    count one wait cycle
//   last      count == TIMEOUT-1: the current wait edge is the TIMEOUT-th
module apb_timeout_counter
    import apb_master_pkg::*;
#(
    parameter int unsigned TIMEOUT = APB_TIMEOUT
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic last
);

    localparam int unsigned CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != CNT_MAX)) begin
            count <= count + 1'b1;
        end
    end

    // Flagging one below TIMEOUT makes the abort coincide with the
    // TIMEOUT-th pready=0 edge rather than one edge later.
    assign last = (count == CNT_LAST);

endmodule

// File: rtl/apb_master_bridge.sv
// APB initiator: turns single valid/ready host commands into APB
// SETUP/ACCESS transfers and returns a one-cycle registered response.
// Ports:
//   clk   system clock (rising edge)
//   rst   asynchronous active-high reset
//   bus   apb_master_bridge_if.master: cmd_*, rsp_*, APB signals
module apb_master_bridge
    import apb_master_pkg::*;
#(
    parameter int unsigned ADDR_W  = APB_ADDR_W,
    parameter int unsigned DATA_W  = APB_DATA_W,
    parameter int unsigned TIMEOUT = APB_TIMEOUT
) (
    input  logic                 clk,
    input  logic                 rst,
    apb_master_bridge_if.master  bus
);

    apb_state_t state;
    apb_state_t next_state;

    logic accept;
    logic done;
    logic abort;
    logic wait_last;

    logic              psel_q;
    logic              penable_q;
    logic              pwrite_q;
    logic [ADDR_W-1:0] paddr_q;
    logic [DATA_W-1:0] pwdata_q;

    logic              rsp_valid_q;
    logic [DATA_W-1:0] rsp_rdata_q;
    logic              rsp_err_q;
    logic              rsp_timeout_q;

    apb_timeout_counter #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk    (clk),
        .rst    (rst),
        .clear  (accept),
        .enable ((state == ACCESS) && !bus.pready),
        .last   (wait_last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        accept     = 1'b0;
        done       = 1'b0;
        abort      = 1'b0;
        case (state)
            IDLE: begin
                if (bus.cmd_valid) begin
                    accept     = 1'b1;
                    next_state = SETUP;
                end
            end
            SETUP: begin
                next_state = ACCESS;
            end
            ACCESS: begin
                // pready on the final wait edge takes priority over abort
                if (bus.pready) begin
                    done       = 1'b1;
                    next_state = IDLE;
                end else if (wait_last) begin
                    abort      = 1'b1;
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // APB outputs are registered from the next state so they line up
    // with the state register without any combinational path to the bus.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            pwrite_q  <= 1'b0;
            paddr_q   <= '0;
            pwdata_q  <= '0;
        end else begin
            psel_q    <= (next_state != IDLE);
            penable_q <= (next_state == ACCESS);
            if (accept) begin
                pwrite_q <= bus.cmd_write;
                paddr_q  <= bus.cmd_addr;
                pwdata_q <= bus.cmd_write ? bus.cmd_wdata : '0;
            end else if (done || abort) begin
                pwdata_q <= '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
        end else begin
            rsp_valid_q <= done || abort;
            if (done) begin
                rsp_rdata_q   <= pwrite_q ? '0 : bus.prdata;
                rsp_err_q     <= bus.pslverr;
                rsp_timeout_q <= 1'b0;
            end else if (abort) begin
                rsp_rdata_q   <= '0;
                rsp_err_q     <= 1'b1;
                rsp_timeout_q <= 1'b1;
            end
        end
    end

    assign bus.cmd_ready   = (state == IDLE);
    assign bus.psel        = psel_q;
    assign bus.penable     = penable_q;
    assign bus.pwrite      = pwrite_q;
    assign bus.paddr       = paddr_q;
    assign bus.pwdata      = pwdata_q;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_rdata   = rsp_rdata_q;
    assign bus.rsp_err     = rsp_err_q;
    assign bus.rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Self-checking bench for apb_master_bridge. The expected response of each
// transfer is derived from the command and the number of wait states the
// bench's slave inserts: ACCESS lasts waits+1 cycles, or TIMEOUT cycles and
// an abort once waits reaches TIMEOUT.
module tb_apb_master_bridge;

    localparam int unsigned AW = 3;
    localparam int unsigned DW = 8;
    localparam int unsigned TO = 15;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int n_tests = 0;
    int n_fail  = 0;

    logic [DW-1:0] last_rdata = '0;
    logic          last_err   = 1'b0;
    logic          last_to    = 1'b0;

    apb_master_bridge_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    apb_master_bridge #(
        .ADDR_W  (AW),
        .DATA_W  (DW),
        .TIMEOUT (TO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One full transfer starting in the current (idle) cycle; returns in the
    // response cycle so a following call issues back-to-back.
    task automatic xfer(input bit wr, input logic [AW-1:0] addr,
                        input logic [DW-1:0] wdata, input logic [DW-1:0] rdata,
                        input bit slverr, input int waits, input bit junk_cmd);
        int            guard;
        int            acc;
        bit            exp_to;
        int            exp_cycles;
        logic [DW-1:0] exp_pwdata;
        logic [DW-1:0] exp_rdata;
        bit            exp_err;

        guard = 0;
        while (!bus.cmd_ready && guard < 50) begin
            step();
            guard++;
        end
        n_tests++;
        if (bus.cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL cmd_ready_wait: got %b want 1", bus.cmd_ready);
        end

        exp_pwdata = wr ? wdata : '0;
        exp_to     = (waits >= int'(TO));
        exp_cycles = exp_to ? int'(TO) : waits + 1;
        exp_rdata  = (!wr && !exp_to) ? rdata : '0;
        exp_err    = exp_to ? 1'b1 : slverr;

        bus.cmd_valid = 1'b1;
        bus.cmd_write = wr;
        bus.cmd_addr  = addr;
        bus.cmd_wdata = wdata;
        bus.pready    = 1'($urandom);
        step();

        // SETUP cycle (k+1)
        n_tests++;
        if ({bus.psel, bus.penable, bus.pwrite, bus.paddr, bus.pwdata,
             bus.cmd_ready, bus.rsp_valid, bus.rsp_rdata} !==
            {1'b1, 1'b0, wr, addr, exp_pwdata, 1'b0, 1'b0, last_rdata}) begin
            n_fail++;
            $display("FAIL setup: got sel=%b en=%b wr=%b addr=%0d wd=%h rdy=%b rv=%b rd=%h want 1 0 %b %0d %h 0 0 %h",
                     bus.psel, bus.penable, bus.pwrite, bus.paddr, bus.pwdata,
                     bus.cmd_ready, bus.rsp_valid, bus.rsp_rdata,
                     wr, addr, exp_pwdata, last_rdata);
        end
        if (junk_cmd) begin
            bus.cmd_valid = 1'b1;
            bus.cmd_write = ~wr;
            bus.cmd_addr  = AW'($urandom);
            bus.cmd_wdata = DW'($urandom);
        end else begin
            bus.cmd_valid = 1'b0;
        end
        bus.pready = 1'($urandom);
        step();

        acc = 0;
        while (bus.psel === 1'b1 && bus.penable === 1'b1 && acc < 40) begin
            n_tests++;
            if ({bus.pwrite, bus.paddr, bus.pwdata, bus.rsp_valid, bus.cmd_ready} !==
                {wr, addr, exp_pwdata, 1'b0, 1'b0}) begin
                n_fail++;
                $display("FAIL access_stable: cyc=%0d got wr=%b addr=%0d wd=%h rv=%b rdy=%b want %b %0d %h 0 0",
                         acc, bus.pwrite, bus.paddr, bus.pwdata, bus.rsp_valid,
                         bus.cmd_ready, wr, addr, exp_pwdata);
            end
            bus.pready  = (acc >= waits);
            bus.prdata  = bus.pready ? rdata  : DW'($urandom);
            bus.pslverr = bus.pready ? slverr : 1'($urandom);
            acc++;
            step();
        end
        bus.cmd_valid = 1'b0;
        bus.pready    = 1'b0;
        bus.pslverr   = 1'b0;

        n_tests++;
        if (acc != exp_cycles) begin
            n_fail++;
            $display("FAIL access_len: got %0d cycles want %0d", acc, exp_cycles);
        end
        n_tests++;
        if ({bus.rsp_valid, bus.psel, bus.penable, bus.pwdata, bus.cmd_ready,
             bus.rsp_rdata, bus.rsp_err, bus.rsp_timeout} !==
            {1'b1, 1'b0, 1'b0, {DW{1'b0}}, 1'b1, exp_rdata, exp_err, exp_to}) begin
            n_fail++;
            $display("FAIL response: got rv=%b sel=%b en=%b wd=%h rdy=%b rd=%h err=%b to=%b want 1 0 0 00 1 %h %b %b",
                     bus.rsp_valid, bus.psel, bus.penable, bus.pwdata, bus.cmd_ready,
                     bus.rsp_rdata, bus.rsp_err, bus.rsp_timeout,
                     exp_rdata, exp_err, exp_to);
        end
        last_rdata = exp_rdata;
        last_err   = exp_err;
        last_to    = exp_to;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            bus.pready = 1'($urandom);
            step();
            n_tests++;
            if ({bus.rsp_valid, bus.psel, bus.penable, bus.cmd_ready,
                 bus.rsp_rdata, bus.rsp_err, bus.rsp_timeout} !==
                {1'b0, 1'b0, 1'b0, 1'b1, last_rdata, last_err, last_to}) begin
                n_fail++;
                $display("FAIL idle_hold: got rv=%b sel=%b en=%b rdy=%b rd=%h err=%b to=%b want 0 0 0 1 %h %b %b",
                         bus.rsp_valid, bus.psel, bus.penable, bus.cmd_ready,
                         bus.rsp_rdata, bus.rsp_err, bus.rsp_timeout,
                         last_rdata, last_err, last_to);
            end
        end
        bus.pready = 1'b0;
    endtask

    task automatic test_reset();
        rst           = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_wdata = '0;
        bus.prdata    = '0;
        bus.pslverr   = 1'b0;
        bus.pready    = 1'b0;
        step();
        step();
        n_tests++;
        if ({bus.psel, bus.penable, bus.pwrite, bus.paddr, bus.pwdata, bus.cmd_ready,
             bus.rsp_valid, bus.rsp_rdata, bus.rsp_err, bus.rsp_timeout} !==
            {1'b0, 1'b0, 1'b0, {AW{1'b0}}, {DW{1'b0}}, 1'b1,
             1'b0, {DW{1'b0}}, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_state: got sel=%b en=%b wr=%b addr=%0d wd=%h rdy=%b rv=%b rd=%h err=%b to=%b want all 0, rdy=1",
                     bus.psel, bus.penable, bus.pwrite, bus.paddr, bus.pwdata, bus.cmd_ready,
                     bus.rsp_valid, bus.rsp_rdata, bus.rsp_err, bus.rsp_timeout);
        end
        rst = 1'b0;
        last_rdata = '0;
        last_err   = 1'b0;
        last_to    = 1'b0;
        idle(2);
    endtask

    task automatic test_write();
        xfer(1'b1, 3'd2, 8'hA5, 8'h00, 1'b0, 0, 1'b0);
        idle(1);
    endtask

    task automatic test_read();
        xfer(1'b0, 3'd6, 8'h77, 8'h3C, 1'b0, 0, 1'b0);
        idle(1);
    endtask

    task automatic test_slverr();
        xfer(1'b1, 3'd7, 8'h5A, 8'h00, 1'b1, 0, 1'b0);
        idle(1);
    endtask

    task automatic test_wait_states();
        xfer(1'b0, 3'd1, 8'h00, 8'h02, 1'b0, 3, 1'b1);
        idle(1);
        // pready=1 on the TIMEOUT-th edge completes normally
        xfer(1'b0, 3'd4, 8'h00, 8'h9E, 1'b0, int'(TO) - 1, 1'b0);
        idle(1);
    endtask

    task automatic test_timeout();
        xfer(1'b0, 3'd3, 8'h00, 8'hFF, 1'b0, int'(TO), 1'b0);
        xfer(1'b1, 3'd5, 8'h11, 8'h00, 1'b0, 0, 1'b0);
        idle(1);
        xfer(1'b0, 3'd0, 8'h00, 8'h44, 1'b1, 40, 1'b1);
        idle(2);
    endtask

    task automatic test_reset_mid();
        bus.cmd_valid = 1'b1;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = 3'd6;
        step();
        bus.cmd_valid = 1'b0;
        bus.pready    = 1'b0;
        step();
        step();
        rst = 1'b1;
        #1;
        n_tests++;
        if ({bus.psel, bus.penable, bus.rsp_valid} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_mid_async: got sel=%b en=%b rv=%b want 0 0 0",
                     bus.psel, bus.penable, bus.rsp_valid);
        end
        bus.pready = 1'b1;
        step();
        rst = 1'b0;
        last_rdata = '0;
        last_err   = 1'b0;
        last_to    = 1'b0;
        idle(1);
    endtask

    task automatic test_back_to_back();
        xfer(1'b1, 3'd2, 8'hC3, 8'h00, 1'b0, 0, 1'b0);
        xfer(1'b0, 3'd2, 8'h00, 8'h81, 1'b0, 0, 1'b0);
        xfer(1'b0, 3'd7, 8'h00, 8'h18, 1'b1, 1, 1'b1);
        idle(1);
    endtask

    task automatic test_random();
        for (int n = 0; n < 25; n++) begin
            int r;
            int waits;
            r = int'($urandom_range(0, 9));
            waits = (r < 6) ? (r % 4) : int'(TO) - 2 + int'($urandom_range(0, 3));
            xfer(1'($urandom), AW'($urandom), DW'($urandom), DW'($urandom),
                 1'($urandom), waits, 1'($urandom));
            idle(int'($urandom_range(0, 2)));
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_slverr();
        test_wait_states();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
